pipe_skid_stage: RTL
====================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter NOP_DATA, default 32'h00000013, value presented when the stage holds no valid data.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, discards all held entries.
REQ-006 SHALL have port in_valid_i, input, 1, upstream data valid.
REQ-007 SHALL have port in_ready_o, output, 1, stage can accept; registered, no combinational path from out_ready_i.
REQ-008 SHALL have port in_data_i, input, DW, upstream data.
REQ-009 SHALL have port out_valid_o, output, 1, downstream data valid.
REQ-010 SHALL have port out_ready_i, input, 1, downstream accepts.
REQ-011 SHALL have port out_data_o, output, DW, downstream data; registered.

Function
REQ-012 SHALL transfer upstream when in_valid_i && in_ready_o, and downstream when out_valid_o && out_ready_i, at the same posedge.
REQ-013 SHALL hold two entries: main (drives out_*) and skid; state machine EMPTY (none), BUSY (main only), FULL (main+skid).
REQ-014 SHALL transition EMPTY->BUSY on an upstream transfer; data appears on out_data_o the next cycle (latency 1).
REQ-015 SHALL, in BUSY: stay BUSY on both transfers or neither (main loads in_data_i on both); go EMPTY on downstream only; go FULL on upstream only, capturing in_data_i into skid.
REQ-016 SHALL, in FULL: move skid to main and go BUSY on downstream transfer; otherwise hold both.
REQ-017 SHALL drive in_ready_o = 1 in EMPTY and BUSY, 0 in FULL; out_valid_o = 1 in BUSY and FULL.
REQ-018 SHALL preserve order; no entry lost or duplicated under any valid/ready pattern.
REQ-019 SHALL drive out_data_o = NOP_DATA whenever out_valid_o = 0.
REQ-020 SHALL hold out_data_o stable while out_valid_o && !out_ready_i.
REQ-021 SHALL, on flush_i = 1, go EMPTY next cycle with out_data_o = NOP_DATA, in_ready_o = 1; a same-cycle upstream transfer is discarded; downstream transfer in that cycle still counts as completed.
REQ-022 SHALL ignore in_data_i when in_valid_i = 0.

Reset
REQ-023 SHALL, when rst = 1 at posedge clk, enter EMPTY: out_valid_o = 0, out_data_o = NOP_DATA, in_ready_o = 1, skid cleared to NOP_DATA.
REQ-024 SHALL give rst priority over flush_i and all transfers, including mid-operation in FULL.
REQ-025 SHALL accept an upstream transfer in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, when macro PIPE_SKID_STALL_CNT_EN is defined, add output stall_cnt_o, 16 bits: increments each cycle with out_valid_o && !out_ready_i, saturates at 16'hFFFF, cleared by rst only (not flush_i).
REQ-027 SHALL, when PIPE_SKID_STALL_CNT_EN is undefined, omit stall_cnt_o and its logic; all other behaviour identical.

Verification
REQ-028 SHALL cover reset: rst=1 one cycle -> out_valid_o=0, out_data_o=32'h00000013, in_ready_o=1.
REQ-029 SHALL cover streaming: out_ready_i=1, inputs 0xA0..0xA7 on consecutive cycles -> outputs 0xA0..0xA7 consecutive, each one cycle later, in_ready_o stays 1.
REQ-030 SHALL cover backpressure: out_ready_i=0, send 0x11, 0x22 -> FULL, in_ready_o=0, out_data_o holds 0x11; raise out_ready_i -> 0x11 then 0x22, no loss.
REQ-031 SHALL cover flush in FULL with in_valid_i=1 data 0x33 -> next cycle out_valid_o=0, out_data_o=NOP_DATA, 0x33 never emitted.
REQ-032 SHALL cover reset mid-operation: FULL with 0x44,0x55, rst=1 -> EMPTY, neither emitted; next input 0x66 emitted first.
REQ-033 SHALL cover (macro defined): out_ready_i=0 for 5 cycles while valid -> stall_cnt_o=5; flush_i -> still 5; rst -> 0.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry valid/ready skid stage with registered ready and data
// Optional stall counter output stall_cnt_o is built when PIPE_SKID_STALL_CNT_EN is defined.
module pipe_skid_stage #(
  parameter int unsigned    DW       = 32,
  parameter logic [DW-1:0]  NOP_DATA = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          up_xfer;
  logic          dn_xfer;

  assign up_xfer = in_valid_i && in_ready_o;
  assign dn_xfer = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_DATA;
      skid_q  <= NOP_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Empty entries are parked at NOP_DATA so out_data_o stays a plain flop output.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = NOP_DATA;
      skid_d  = NOP_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_BUSY;
            main_d  = in_data_i;
          end
        end
        ST_BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_d = in_data_i;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
            main_d  = NOP_DATA;
          end else if (up_xfer) begin
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (dn_xfer) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = NOP_DATA;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_DATA;
          skid_d  = NOP_DATA;
        end
      endcase
    end
  end

  // Handshake outputs decode only the state register, never out_ready_i.
  always_comb begin
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
      end
      ST_BUSY: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b1;
      end
      ST_FULL: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b1;
      end
      default: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
      end
    endcase
  end

  assign out_data_o = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
